// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side valid/ready channels, the FIFO write port and the
//   FIFO status flags used by fifo_wr_arbiter.
//
//   Signals
//     req_valid   NUM_REQ         producer n has a beat
//     req_data    NUM_REQ*DATA_W  beat of producer n in slice [n*DATA_W +: DATA_W]
//     req_ready   NUM_REQ         one-hot (or zero) accept from the arbiter
//     i_wren      1               FIFO write enable
//     i_wrdata    DATA_W          FIFO write data
//     o_full      1               FIFO full flag
//     o_alm_full  1               FIFO almost-full flag
//     grant_id    $clog2(NUM_REQ) producer behind the current i_wren
//     stall       1               arbitration blocked by FIFO flags
//
//   Modports
//     slave   : the arbiter itself
//     master  : the environment (producers + FIFO status)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      i_wren;
  logic [DATA_W-1:0]         i_wrdata;
  logic                      o_full;
  logic                      o_alm_full;
  logic [ID_W-1:0]           grant_id;
  logic                      stall;

  modport slave (
    input  req_valid,
    input  req_data,
    input  o_full,
    input  o_alm_full,
    output req_ready,
    output i_wren,
    output i_wrdata,
    output grant_id,
    output stall
  );

  modport master (
    output req_valid,
    output req_data,
    output o_full,
    output o_alm_full,
    input  req_ready,
    input  i_wren,
    input  i_wrdata,
    input  grant_id,
    input  stall
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
//   One winning beat per cycle is registered onto i_wren/i_wrdata/grant_id.
//   Arbitration is blocked while the FIFO reports full or almost-full; the beat
//   already registered still writes, landing in the entry the FIFO guarantees
//   free while almost-full is asserted.
//
//   Ports
//     clk   in  clock, all logic on posedge
//     rst   in  synchronous, active-high reset
//     bus   fifo_wr_arbiter_if.slave (valid/ready channels, FIFO write port,
//           FIFO flags, grant_id, stall)
//
//   Parameters
//     NUM_REQ    number of requesters (2..8)
//     DATA_W     write data width
//     MAX_BURST  max consecutive beats per grant in burst mode (1..16)
//
//   Configuration macro
//     FIFO_WR_ARB_BURST_EN : when defined, a winner keeps the grant (LOCK) for
//     up to MAX_BURST consecutive beats. Undefined: per-beat round-robin.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Elaboration-time parameter range check.
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (MAX_BURST < 1) || (MAX_BURST > 16)) begin : g_cfg_check
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..16");
  end

  // Round-robin successor of a requester index, wrapping NUM_REQ-1 -> 0.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    if (int'(idx) == (NUM_REQ - 1)) begin
      return '0;
    end else begin
      return idx + ID_W'(1);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              wren_q,   wren_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [ID_W-1:0]   grant_q,  grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [ID_W-1:0]    owner_q,     owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic               stall_s;
  logic               found_s;
  logic [ID_W-1:0]    winner_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] req_ready_s;

  // FIFO back-pressure: almost-full already blocks, so full never sees a write.
  always_comb begin
    stall_s = bus.o_full | bus.o_alm_full;
  end

  // Winner search: first valid requester from rr_ptr upward, wrapping.
  // In burst LOCK only the current owner may win.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found_s && bus.req_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = ID_W'(idx);
      end else begin
        found_s  = found_s;
      end
    end
`ifdef FIFO_WR_ARB_BURST_EN
    if (state_q == ST_LOCK) begin
      found_s  = bus.req_valid[owner_q];
      winner_s = owner_q;
    end else begin
      found_s  = found_s;
    end
`endif
  end

  // Accept only when the FIFO has room and we are out of reset; ready is the
  // one-hot decode of the winner gated by the same condition.
  always_comb begin
    accept_s    = found_s & ~stall_s & ~rst;
    req_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept_s && (int'(winner_s) == i)) begin
        req_ready_s[i] = 1'b1;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Write-port register: data and grant_id hold their last value when idle.
  always_comb begin
    wren_d   = accept_s;
    wrdata_d = wrdata_q;
    grant_d  = grant_q;
    if (accept_s) begin
      wrdata_d = bus.req_data[int'(winner_s)*DATA_W +: DATA_W];
      grant_d  = winner_s;
    end else begin
      wrdata_d = wrdata_q;
      grant_d  = grant_q;
    end
  end

`ifdef FIFO_WR_ARB_BURST_EN
  // Burst FSM and round-robin pointer. The pointer only advances when a
  // grant is released, so the owner keeps priority for the whole burst.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = next_idx(winner_s);
          end else begin
            state_d     = ST_LOCK;
            owner_d     = winner_s;
            burst_cnt_d = BURST_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (accept_s) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        // Release on burst limit, owner dropping valid, or back-pressure.
        // A beat accepted on the limit cycle is already in wrdata_d.
        if (!found_s || stall_s || (accept_s && (burst_cnt_d == BURST_W'(MAX_BURST)))) begin
          state_d     = ST_IDLE;
          rr_ptr_d    = next_idx(owner_q);
          burst_cnt_d = '0;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        owner_d     = '0;
        burst_cnt_d = '0;
        rr_ptr_d    = '0;
      end
    endcase
  end
`else
  // Per-beat round-robin: the just-served requester drops to lowest priority.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_s) begin
      rr_ptr_d = next_idx(winner_s);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // State update; reset drops any in-flight beat and restarts at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_q      <= 1'b0;
      wrdata_q    <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      burst_cnt_q <= '0;
`endif
    end else begin
      wren_q      <= wren_d;
      wrdata_q    <= wrdata_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef FIFO_WR_ARB_BURST_EN
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready_s;
  assign bus.stall     = stall_s;
  assign bus.i_wren    = wren_q;
  assign bus.i_wrdata  = wrdata_q;
  assign bus.grant_id  = grant_q;

endmodule
